// File: rtl/sha3_pkg.sv
// Shared widths and FSM encoding for the 48-bit Keccak state link.
package sha3_pkg;

    localparam int LANE_W          = 64;
    localparam int SLICE_W         = 48;
    localparam int SLICE_COUNT     = 34;
    localparam int SPARE_W         = 16;
    localparam int PAD_W           = 16;
    localparam int GROUPS          = 5;
    localparam int LANES_PER_GROUP = 5;
    localparam int LANES           = GROUPS * LANES_PER_GROUP;
    localparam int CNT_W           = 6;
    localparam int STATE_W         = SLICE_W * SLICE_COUNT;

    typedef enum logic {
        ST_GATHER = 1'b0,
        ST_HOLD   = 1'b1
    } gather_state_e;

endpackage

// File: rtl/sha3_state_unslice_from_48.sv
// Combinational inverse of the 48-bit slicer: slot buffer -> 25 lanes, spare and pad.
module sha3_state_unslice_from_48
    import sha3_pkg::*;
(
    input  logic [SLICE_W-1:0] slot  [SLICE_COUNT],
    output logic [LANE_W-1:0]  sa    [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  sb    [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  sc    [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  sd    [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  se    [LANES_PER_GROUP],
    output logic [SPARE_W-1:0] spare,
    output logic [PAD_W-1:0]   pad
);

    // Slot 0 occupies the most significant end of the flat state.
    logic [STATE_W-1:0] flat;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE_COUNT; gi++) begin : g_flat
            assign flat[STATE_W-1-SLICE_W*gi -: SLICE_W] = slot[gi];
        end

        for (gi = 0; gi < LANES_PER_GROUP; gi++) begin : g_lane
            assign sa[gi] = flat[STATE_W-1-LANE_W*(0*LANES_PER_GROUP+gi) -: LANE_W];
            assign sb[gi] = flat[STATE_W-1-LANE_W*(1*LANES_PER_GROUP+gi) -: LANE_W];
            assign sc[gi] = flat[STATE_W-1-LANE_W*(2*LANES_PER_GROUP+gi) -: LANE_W];
            assign sd[gi] = flat[STATE_W-1-LANE_W*(3*LANES_PER_GROUP+gi) -: LANE_W];
            assign se[gi] = flat[STATE_W-1-LANE_W*(4*LANES_PER_GROUP+gi) -: LANE_W];
        end
    endgenerate

    assign spare = flat[SPARE_W-1:0];
    assign pad   = flat[SPARE_W+PAD_W-1:SPARE_W];

endmodule

// File: rtl/sha3_state_gather_from_48.sv
// Collects 34 slice words into a slot buffer and presents the rebuilt Keccak
// state for one valid/ready transfer.
module sha3_state_gather_from_48
    import sha3_pkg::*;
#(
    parameter bit CHECK_PAD = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ivalid,
    input  logic [SLICE_W-1:0] idata,
    output logic               iready,
    output logic               ovalid,
    input  logic               oready,
    output logic [LANE_W-1:0]  osa [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  osb [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  osc [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  osd [LANES_PER_GROUP],
    output logic [LANE_W-1:0]  ose [LANES_PER_GROUP],
    output logic [SPARE_W-1:0] ospare,
    output logic               opad_err
);

    gather_state_e      state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SLICE_W-1:0] slot_reg [SLICE_COUNT];
    logic [PAD_W-1:0]   pad;
    logic               accept;
    logic               last_word;

    assign accept    = (state_reg == ST_GATHER) && ivalid;
    assign last_word = (cnt_reg == CNT_W'(SLICE_COUNT-1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        iready     = 1'b0;
        ovalid     = 1'b0;
        case (state_reg)
            ST_GATHER: begin
                iready = 1'b1;
                if (ivalid) begin
                    if (last_word) begin
                        cnt_next   = '0;
                        state_next = ST_HOLD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                ovalid = 1'b1;
                if (oready) begin
                    state_next = ST_GATHER;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_GATHER;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // One register per slot, enabled by its own counter decode.
    genvar gi;
    generate
        for (gi = 0; gi < SLICE_COUNT; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= '0;
                end else if (accept && (cnt_reg == CNT_W'(gi))) begin
                    slot_reg[gi] <= idata;
                end
            end
        end
    endgenerate

    sha3_state_unslice_from_48 u_unslice (
        .slot  (slot_reg),
        .sa    (osa),
        .sb    (osb),
        .sc    (osc),
        .sd    (osd),
        .se    (ose),
        .spare (ospare),
        .pad   (pad)
    );

    // Slot 33 only changes when word 33 is accepted, so this acts as the latched flag.
    assign opad_err = CHECK_PAD && (pad != '0);

endmodule

// File: tb/tb_sha3_state_gather_from_48.sv
// Randomized bench for the 48-bit state gatherer against a lane-level reference model.
module tb_sha3_state_gather_from_48;
    import sha3_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ivalid;
    logic [47:0] idata;
    logic        oready;

    logic        iready, ovalid, opad_err;
    logic [63:0] osa [5], osb [5], osc [5], osd [5], ose [5];
    logic [15:0] ospare;

    logic        np_iready, np_ovalid, np_opad_err;
    logic [63:0] np_sa [5], np_sb [5], np_sc [5], np_sd [5], np_se [5];
    logic [15:0] np_spare;

    always #5 clk = ~clk;

    sha3_state_gather_from_48 #(.CHECK_PAD(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ivalid(ivalid), .idata(idata), .iready(iready),
        .ovalid(ovalid), .oready(oready), .osa(osa), .osb(osb), .osc(osc),
        .osd(osd), .ose(ose), .ospare(ospare), .opad_err(opad_err)
    );

    sha3_state_gather_from_48 #(.CHECK_PAD(1'b0)) u_dut_np (
        .clk(clk), .rst_n(rst_n), .ivalid(ivalid), .idata(idata), .iready(np_iready),
        .ovalid(np_ovalid), .oready(oready), .osa(np_sa), .osb(np_sb), .osc(np_sc),
        .osd(np_sd), .ose(np_se), .ospare(np_spare), .opad_err(np_opad_err)
    );

    logic [63:0] dut_lane [25];
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dut_lane[i]      = osa[i];
            dut_lane[5 + i]  = osb[i];
            dut_lane[10 + i] = osc[i];
            dut_lane[15 + i] = osd[i];
            dut_lane[20 + i] = ose[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: words <-> lanes through a flat 1632-bit state.
    logic [47:0] words [34];
    logic [63:0] exp_lane [25];
    logic [15:0] exp_spare;
    logic        exp_pad_err;

    task automatic model_from_words();
        logic [1631:0] flat;
        flat = '0;
        for (int k = 0; k < 34; k++) flat = {flat[1583:0], words[k]};
        for (int n = 0; n < 25; n++) exp_lane[n] = flat[1631 - 64*n -: 64];
        exp_spare   = words[33][15:0];
        exp_pad_err = (words[33][31:16] != 16'h0);
    endtask

    task automatic slice_lanes(input logic [15:0] spare);
        logic [1631:0] flat;
        flat = '0;
        for (int n = 0; n < 25; n++) flat = {flat[1567:0], exp_lane[n]};
        flat = {flat[1599:0], 16'h0000, spare};
        for (int k = 0; k < 34; k++) words[k] = flat[1631 - 48*k -: 48];
        exp_spare   = spare;
        exp_pad_err = 1'b0;
    endtask

    task automatic random_words();
        for (int k = 0; k < 34; k++) words[k] = {16'($urandom()), 32'($urandom())};
    endtask

    task automatic push(input logic [47:0] w, input int gap_pct);
        int waited;
        waited = 0;
        while ($urandom_range(99) < gap_pct) begin
            ivalid = 1'b0;
            idata  = 48'($urandom());
            @(negedge clk);
        end
        ivalid = 1'b1;
        idata  = w;
        while (!iready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!iready) check("push_timeout", 64'(iready), 64'd1);
        @(negedge clk);
        ivalid = 1'b0;
    endtask

    task automatic gather(input string tag, input int gap_pct);
        for (int k = 0; k < 34; k++) begin
            if (k > 0) begin
                check($sformatf("%s_early_ovalid_w%0d", tag, k), 64'(ovalid), 64'd0);
            end
            push(words[k], gap_pct);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ovalid"}, 64'(ovalid), 64'd1);
        check({tag, "_iready"}, 64'(iready), 64'd0);
        for (int n = 0; n < 25; n++) begin
            check($sformatf("%s_lane%0d", tag, n), dut_lane[n], exp_lane[n]);
        end
        check({tag, "_ospare"}, 64'(ospare), 64'(exp_spare));
        check({tag, "_opad_err"}, 64'(opad_err), 64'(exp_pad_err));
        check({tag, "_np_ovalid"}, 64'(np_ovalid), 64'd1);
        check({tag, "_np_opad_err"}, 64'(np_opad_err), 64'd0);
    endtask

    task automatic release_state(input string tag, input int hold_cycles);
        oready = 1'b0;
        for (int c = 0; c < hold_cycles; c++) begin
            ivalid = 1'b1;
            idata  = {16'($urandom()), 32'($urandom())};
            @(negedge clk);
            check($sformatf("%s_hold%0d_iready", tag, c), 64'(iready), 64'd0);
            check($sformatf("%s_hold%0d_ovalid", tag, c), 64'(ovalid), 64'd1);
            check($sformatf("%s_hold%0d_lane0", tag, c), dut_lane[0], exp_lane[0]);
            check($sformatf("%s_hold%0d_lane24", tag, c), dut_lane[24], exp_lane[24]);
            check($sformatf("%s_hold%0d_ospare", tag, c), 64'(ospare), 64'(exp_spare));
        end
        ivalid = 1'b0;
        oready = 1'b1;
        @(negedge clk);
        check({tag, "_release_ovalid"}, 64'(ovalid), 64'd0);
        check({tag, "_release_iready"}, 64'(iready), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_iready"}, 64'(iready), 64'd1);
        check({tag, "_ovalid"}, 64'(ovalid), 64'd0);
        for (int n = 0; n < 25; n++) begin
            check($sformatf("%s_lane%0d", tag, n), dut_lane[n], 64'd0);
        end
        check({tag, "_ospare"}, 64'(ospare), 64'd0);
        check({tag, "_opad_err"}, 64'(opad_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        oready = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Counting pattern with oready held high.
        oready = 1'b1;
        for (int k = 0; k < 34; k++) words[k] = {16'(k), 32'hA5A5_0000 | 32'(k)};
        model_from_words();
        gather("t1", 0);
        check_state("t1");
        check("t1_ospare_0021", 64'(ospare), 64'h0021);
        release_state("t1", 0);

        // Known lane values sliced by the model.
        for (int n = 0; n < 25; n++) exp_lane[n] = 64'h0101_0101_0101_0101 * 64'(n);
        slice_lanes(16'hBEEF);
        gather("t2", 0);
        check_state("t2");
        release_state("t2", 0);

        // Backpressure in HOLD.
        random_words();
        model_from_words();
        gather("t3", 0);
        check_state("t3");
        release_state("t3", 10);

        // Random ivalid gaps over three states.
        for (int s = 0; s < 3; s++) begin
            random_words();
            model_from_words();
            gather($sformatf("t4s%0d", s), 50);
            check_state($sformatf("t4s%0d", s));
            release_state($sformatf("t4s%0d", s), int'($urandom_range(3)));
        end

        // Nonzero pad bits.
        random_words();
        words[33] = 48'h0000_0001_1234;
        model_from_words();
        gather("t5", 0);
        check_state("t5");
        check("t5_pad_err_set", 64'(opad_err), 64'd1);
        check("t5_ospare_1234", 64'(ospare), 64'h1234);
        release_state("t5", 0);

        // Reset in the middle of a gather.
        random_words();
        for (int k = 0; k < 18; k++) push(words[k], 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("t6_in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_cleared("t6_after_reset");
        random_words();
        model_from_words();
        gather("t6", 0);
        check_state("t6");
        release_state("t6", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha3_state_gather_from_48.md
# sha3_state_gather_from_48

Deserializer that rebuilds a full Keccak-f[1600] state from the 48-bit slice stream produced by the state slicer. It accepts 34 words over a valid/ready interface, reassembles the 25 lanes (five groups a..e of five 64-bit lanes) plus the 16 spare bits, and presents the whole state for one transfer on a valid/ready output. It sits at the receive end of the narrow 48-bit state link, feeding the permutation or digest stage.

## Interface
- CHECK_PAD, 1: when 1, nonzero pad bits in word 33 raise `opad_err`; when 0, `opad_err` is tied 0.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ivalid  in  1  slice word valid
- idata  in  48  slice word
- iready  out  1  block accepts `idata` this cycle
- ovalid  out  1  reassembled state valid
- oready  in  1  downstream accepts state
- osa, osb, osc, osd, ose  out  64 x [5] each  reassembled lanes
- ospare  out  16  spare bits carried in word 33 [15:0]
- opad_err  out  1  word 33 [31:16] was nonzero; qualified by `ovalid`

## Operation
- Word k (0..33) is stored in buffer slot k. Flat view F[1631:0] = {slot0, slot1, ..., slot33}, slot0 most significant.
- Lane n = 5*g + i (g: a=0..e=4, i=0..4) = F[1631-64n -: 64]; e.g. osa[0] = {slot0, slot1[47:32]}, osa[2] = {slot2[15:0], slot3}, ose[4] = {slot32, slot33[47:32]}.
- ospare = slot33[15:0]; pad = slot33[31:16]; opad_err = CHECK_PAD && (pad != 0), latched on acceptance of word 33.
- FSM, two states:
  - GATHER: iready=1, ovalid=0. On ivalid&&iready write slot[cnt]; cnt increments. At cnt==33 the accept moves to HOLD, cnt returns to 0.
  - HOLD: iready=0, ovalid=1, outputs stable. On oready go to GATHER.
- ivalid while iready=0 is ignored; upstream holds data (standard valid/ready).
- No partial-state flush; a state is emitted only after exactly 34 accepted words.
- Reset (any time, including mid-gather or in HOLD): state GATHER, cnt 0, all slots 0, opad_err 0. Outputs after reset: iready 1, ovalid 0, all lanes 0, ospare 0. A partially gathered state is discarded.

## Timing
- Write of word k takes effect on the accepting edge; ovalid rises the cycle after word 33 is accepted (1-cycle latency from last accept).
- HOLD->GATHER on the oready edge; iready is 1 the following cycle. Minimum period: 34 accept cycles + 1 HOLD cycle = 35 cycles per state.
- iready and ovalid are decoded from the registered FSM state only; no combinational path from oready or ivalid to any output.
- Lane outputs are pure wiring from registered slots; they change only on accepts, never during HOLD.
- cnt is 6 bits; it never exceeds 33, with no wrap past 33.

## Structure
- Package sha3_pkg: LANE_W=64, SLICE_W=48, SLICE_COUNT=34, SPARE_W=16, GROUPS=5, LANES_PER_GROUP=5; FSM state enum.
- Sub-module sha3_state_unslice_from_48: purely combinational inverse mapping from slot[34] to the five lane arrays, ospare, and pad. The top module holds the buffer, counter, FSM, and handshake.

## Test plan
- Reset, then 34 words with idata = {16'hk, 32'hA5A5_0000 | k}, ivalid held, oready=1 -> ovalid exactly one cycle after word 33 for one cycle; each lane matches the flat mapping; ospare = 16'h0021.
- Known state: lane n = 64'h0101_0101_0101_0101 * n, sliced by the reference model with spare 16'hBEEF -> all 25 lanes bit-exact; ospare = 16'hBEEF; opad_err = 0.
- Backpressure: oready=0 for 10 cycles in HOLD while ivalid=1 -> iready=0 throughout, outputs stable; the next state starts cleanly after oready.
- Random ivalid gaps (50%) over 3 states -> each state is correct, the counter never skips, and no state is emitted early.
- Word 33 = 48'h0000_0001_1234 with CHECK_PAD=1 -> opad_err=1 and ospare=16'h1234. With CHECK_PAD=0 -> opad_err=0.
- Assert rst_n low after word 17, then release -> ovalid=0, lanes 0, iready=1; 34 fresh words yield the correct state with no residue.
